// File: rtl/ff_array_port_ctrl.sv
// ff_array_port_ctrl: valid/ready front end for a csb/web single-port array; a read accepted in cycle N responds in N+1.
// Under response backpressure csb0 stays high so dout0 holds; ARRAY_PORT_CTRL_INIT_EN adds a post-reset INIT_VAL sweep.
module ff_array_port_ctrl #(
  parameter int unsigned      S_INDEX  = 4,
  parameter int unsigned      WIDTH    = 1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic               clk0,
  input  logic               rst0,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [S_INDEX-1:0] req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               init_done,
  output logic               csb0,
  output logic               web0,
  output logic [S_INDEX-1:0] addr0,
  output logic [WIDTH-1:0]   din0,
  input  logic [WIDTH-1:0]   dout0
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_RD_RSP = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   req_acc;
  logic   req_rd_acc;

`ifdef ARRAY_PORT_CTRL_INIT_EN
  localparam state_e RESET_STATE = ST_INIT;
  localparam logic [S_INDEX:0] LAST_SET = {1'b0, {S_INDEX{1'b1}}};

  // One extra bit so the counter never aliases back onto set 0 at the end of the sweep.
  logic [S_INDEX:0] init_cnt_q, init_cnt_d;
`else
  localparam state_e RESET_STATE = ST_IDLE;

  logic [WIDTH-1:0] unused_init_val;
  assign unused_init_val = INIT_VAL;
`endif

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    if (!rst0) begin
      case (state_q)
        ST_IDLE:   req_ready = 1'b1;
        ST_RD_RSP: begin
          rsp_valid = 1'b1;
          req_ready = rsp_ready;
        end
        default:   req_ready = 1'b0;
      endcase
    end
  end

  assign req_acc    = req_valid & req_ready;
  assign req_rd_acc = req_acc & ~req_we;

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef ARRAY_PORT_CTRL_INIT_EN
      ST_INIT:   if (init_cnt_q == LAST_SET) state_d = ST_IDLE;
`endif
      ST_IDLE:   if (req_rd_acc) state_d = ST_RD_RSP;
      ST_RD_RSP: if (rsp_ready) state_d = req_rd_acc ? ST_RD_RSP : ST_IDLE;
      default:   state_d = RESET_STATE;
    endcase
  end

`ifdef ARRAY_PORT_CTRL_INIT_EN
  always_comb begin
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) init_cnt_d = init_cnt_q + 1'b1;
  end
`endif

  // Issue in the accept cycle; a stalled response keeps csb0 high so the array output holds.
  always_comb begin
    csb0  = ~req_acc;
    web0  = ~req_we;
    addr0 = req_addr;
    din0  = req_wdata;
`ifdef ARRAY_PORT_CTRL_INIT_EN
    if (state_q == ST_INIT) begin
      csb0  = 1'b0;
      web0  = 1'b0;
      addr0 = init_cnt_q[S_INDEX-1:0];
      din0  = INIT_VAL;
    end
`endif
    if (rst0) begin
      csb0 = 1'b1;
      web0 = 1'b1;
    end
  end

  assign rsp_rdata = dout0;
  assign init_done = (state_q != ST_INIT) && !rst0;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q    <= RESET_STATE;
`ifdef ARRAY_PORT_CTRL_INIT_EN
      init_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
`ifdef ARRAY_PORT_CTRL_INIT_EN
      init_cnt_q <= init_cnt_d;
`endif
    end
  end

endmodule
